// File: rtl/nes_mmc1_if.sv
// CPU-side bus, PPU A12 and flash/SRAM-facing signals of the MMC1 bank controller.
// The master modport is the board/CPU side and the slave modport is the mapper.
interface nes_mmc1_if;
  logic [15:0] i_bus_addr;
  logic [7:0]  i_bus_wdata;
  logic        i_bus_r_wn;
  logic        i_bus_wstb;
  logic        i_ppu_a12;
  logic [7:0]  i_fl_rdata;
  logic [7:0]  o_mmc_rdata;
  logic [22:0] o_fl_addr;
  logic [7:0]  o_sram_addr_ext;
  logic [2:0]  o_mirror_mode;
  logic        o_wram_en;
  logic        o_irq_n;

  modport master (
    output i_bus_addr, i_bus_wdata, i_bus_r_wn, i_bus_wstb, i_ppu_a12, i_fl_rdata,
    input  o_mmc_rdata, o_fl_addr, o_sram_addr_ext, o_mirror_mode, o_wram_en, o_irq_n
  );

  modport slave (
    input  i_bus_addr, i_bus_wdata, i_bus_r_wn, i_bus_wstb, i_ppu_a12, i_fl_rdata,
    output o_mmc_rdata, o_fl_addr, o_sram_addr_ext, o_mirror_mode, o_wram_en, o_irq_n
  );
endinterface

// File: rtl/nes_mmc1_ctrl.sv
// MMC1 (iNES mapper 1) bank controller: 5-write serial load port feeding four bank
// registers, which drive the PRG flash address, CHR SRAM bank extension and mirroring.
module nes_mmc1_ctrl #(
  parameter int PRG_BANKS = 16,
  parameter int CHR_BANKS = 32,
  parameter int WR_GAP    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  nes_mmc1_if.slave  bus
);

  localparam int             GW       = (WR_GAP < 2) ? 1 : $clog2(WR_GAP + 1);
  localparam logic [GW-1:0]  GAP_LD   = GW'(WR_GAP);
  localparam logic [7:0]     PRG_MASK = 8'(PRG_BANKS - 1);
  localparam logic [7:0]     CHR_MASK = 8'(CHR_BANKS - 1);
  localparam logic [4:0]     SR_INIT  = 5'b10000;
  localparam logic [4:0]     CTL_INIT = 5'h0C;

  logic [4:0]    sr_q,   sr_d;
  logic [4:0]    ctl_q,  ctl_d;
  logic [4:0]    chr0_q, chr0_d;
  logic [4:0]    chr1_q, chr1_d;
  logic [4:0]    prg_q,  prg_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  logic       wr_evt;
  logic       wr_acc;
  logic [4:0] shift_v;
  logic [7:0] prg_bank;
  logic [4:0] chr_bank;
  logic       unused_wdata;

  function automatic logic [2:0] mirror_of(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd0;
      2'd1:    return 3'd3;
      2'd2:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  // Unmasked 16 KB bank for the current PRG mode; the top bank is all-ones before masking.
  function automatic logic [7:0] prg_bank_of(input logic [1:0] mode, input logic [3:0] prg,
                                             input logic a14);
    case (mode)
      2'd0, 2'd1: return {4'h0, prg[3:1], a14};
      2'd2:       return a14 ? {4'h0, prg} : 8'h00;
      default:    return a14 ? 8'hFF : {4'h0, prg};
    endcase
  endfunction

  function automatic logic [4:0] chr_bank_of(input logic mode4k, input logic [4:0] chr0,
                                             input logic [4:0] chr1, input logic a12);
    if (mode4k) return a12 ? chr1 : chr0;
    return {chr0[4:1], a12};
  endfunction

  always_comb begin
    sr_d    = sr_q;
    ctl_d   = ctl_q;
    chr0_d  = chr0_q;
    chr1_d  = chr1_q;
    prg_d   = prg_q;
    gcnt_d  = gcnt_q;
    wr_evt  = bus.i_bus_wstb & ~bus.i_bus_r_wn & bus.i_bus_addr[15];
    wr_acc  = wr_evt && (gcnt_q == '0);
    shift_v = {bus.i_bus_wdata[0], sr_q[4:1]};

    // Every write event restarts the gap window, even one that is itself filtered out.
    if (wr_evt) begin
      gcnt_d = GAP_LD;
    end else if (gcnt_q != '0) begin
      gcnt_d = gcnt_q - GW'(1);
    end

    if (wr_acc) begin
      if (bus.i_bus_wdata[7]) begin
        sr_d  = SR_INIT;
        ctl_d = ctl_q | 5'h0C;
      end else if (!sr_q[0]) begin
        sr_d = shift_v;
      end else begin
        // Sentinel reached bit 0: this is the fifth write, commit and rearm.
        sr_d = SR_INIT;
        case (bus.i_bus_addr[14:13])
          2'd0:    ctl_d  = shift_v;
          2'd1:    chr0_d = shift_v;
          2'd2:    chr1_d = shift_v;
          default: prg_d  = shift_v;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q   <= SR_INIT;
      ctl_q  <= CTL_INIT;
      chr0_q <= '0;
      chr1_q <= '0;
      prg_q  <= '0;
      gcnt_q <= '0;
    end else begin
      sr_q   <= sr_d;
      ctl_q  <= ctl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
      gcnt_q <= gcnt_d;
    end
  end

  assign prg_bank = prg_bank_of(ctl_q[3:2], prg_q[3:0], bus.i_bus_addr[14]) & PRG_MASK;
  assign chr_bank = chr_bank_of(ctl_q[4], chr0_q, chr1_q, bus.i_ppu_a12);

  assign bus.o_fl_addr       = bus.i_bus_addr[15] ? {1'b0, prg_bank, bus.i_bus_addr[13:0]} : 23'h0;
  assign bus.o_sram_addr_ext = {3'b000, chr_bank} & CHR_MASK;
  assign bus.o_mirror_mode   = mirror_of(ctl_q[1:0]);
  assign bus.o_wram_en       = ~prg_q[4];
  assign bus.o_irq_n         = 1'b1;
  assign bus.o_mmc_rdata     = (bus.i_bus_addr[15] & bus.i_bus_r_wn) ? bus.i_fl_rdata : 8'h00;

  assign unused_wdata = ^bus.i_bus_wdata[6:1];

endmodule

// File: tb/tb_nes_mmc1_ctrl.sv
// Randomized and directed bench for nes_mmc1_ctrl against a register-level reference model.
module tb_nes_mmc1_ctrl;

  localparam int PRG_BANKS = 16;
  localparam int CHR_BANKS = 32;
  localparam int WR_GAP    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nes_mmc1_if bus ();

  nes_mmc1_ctrl #(
    .PRG_BANKS(PRG_BANKS),
    .CHR_BANKS(CHR_BANKS),
    .WR_GAP   (WR_GAP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the serial port is a bit counter plus accumulator, the gap filter
  // compares cycle numbers of write events.
  int m_ctl, m_chr0, m_chr1, m_prg;
  int m_nbits, m_acc, m_last, m_cyc;

  function automatic void m_reset();
    m_ctl   = 12;
    m_chr0  = 0;
    m_chr1  = 0;
    m_prg   = 0;
    m_nbits = 0;
    m_acc   = 0;
    m_last  = -1000;
    m_cyc   = 0;
  endfunction

  function automatic void m_step(input int a, input int wd, input bit rwn, input bit stb);
    if (stb && !rwn && a >= 32768) begin
      if (m_cyc - m_last > WR_GAP) begin
        if (wd >= 128) begin
          m_nbits = 0;
          m_acc   = 0;
          m_ctl   = m_ctl | 12;
        end else begin
          m_acc   = m_acc + ((wd % 2) << m_nbits);
          m_nbits = m_nbits + 1;
          if (m_nbits == 5) begin
            case ((a / 8192) % 4)
              0:       m_ctl  = m_acc;
              1:       m_chr0 = m_acc;
              2:       m_chr1 = m_acc;
              default: m_prg  = m_acc;
            endcase
            m_nbits = 0;
            m_acc   = 0;
          end
        end
      end
      m_last = m_cyc;
    end
    m_cyc++;
  endfunction

  function automatic int exp_fl(input int a);
    int hi, mode, p, b;
    if (a < 32768) return 0;
    hi   = (a / 16384) % 2;
    mode = (m_ctl / 4) % 4;
    p    = m_prg % 16;
    case (mode)
      0, 1:    b = (p / 2) * 2 + hi;
      2:       b = hi ? p : 0;
      default: b = hi ? PRG_BANKS - 1 : p;
    endcase
    return (b % PRG_BANKS) * 16384 + (a % 16384);
  endfunction

  function automatic int exp_chr(input int a12);
    int c;
    if (m_ctl >= 16) c = a12 ? m_chr1 : m_chr0;
    else             c = (m_chr0 / 2) * 2 + a12;
    return c % CHR_BANKS;
  endfunction

  function automatic int exp_mirror();
    case (m_ctl % 4)
      0:       return 0;
      1:       return 3;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    int a, rd;
    a  = int'(bus.i_bus_addr);
    rd = (a >= 32768 && bus.i_bus_r_wn) ? int'(bus.i_fl_rdata) : 0;
    chk({tag, ".fl_addr"}, 32'(bus.o_fl_addr), 32'(exp_fl(a)));
    chk({tag, ".sram_ext"}, 32'(bus.o_sram_addr_ext), 32'(exp_chr(int'(bus.i_ppu_a12))));
    chk({tag, ".mirror"}, 32'(bus.o_mirror_mode), 32'(exp_mirror()));
    chk({tag, ".wram_en"}, 32'(bus.o_wram_en), 32'(m_prg < 16));
    chk({tag, ".irq_n"}, 32'(bus.o_irq_n), 32'd1);
    chk({tag, ".rdata"}, 32'(bus.o_mmc_rdata), 32'(rd));
  endtask

  // One clock: drive just after the rising edge, check at the falling edge, advance model.
  task automatic cyc(input logic [15:0] a, input logic [7:0] wd, input logic rwn,
                     input logic stb, input logic a12, input string tag);
    bus.i_bus_addr  = a;
    bus.i_bus_wdata = wd;
    bus.i_bus_r_wn  = rwn;
    bus.i_bus_wstb  = stb;
    bus.i_ppu_a12   = a12;
    bus.i_fl_rdata  = 8'($urandom);
    @(negedge clk);
    check_outs(tag);
    @(posedge clk);
    m_step(int'(a), int'(wd), rwn, stb);
    #1;
  endtask

  task automatic idle(input logic [15:0] a);
    cyc(a, 8'h00, 1'b1, 1'b0, 1'b0, "idle");
  endtask

  task automatic ser(input logic [15:0] a, input logic b);
    cyc(a, {7'd0, b}, 1'b0, 1'b1, 1'b0, "ser");
    idle(a);
    idle(a);
  endtask

  task automatic load(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) ser(a, v[i]);
  endtask

  task automatic probe(input logic [15:0] a, input logic a12);
    bus.i_bus_addr  = a;
    bus.i_bus_wdata = 8'h00;
    bus.i_bus_r_wn  = 1'b1;
    bus.i_bus_wstb  = 1'b0;
    bus.i_ppu_a12   = a12;
    bus.i_fl_rdata  = 8'h5A;
    #2;
  endtask

  task automatic do_reset();
    bus.i_bus_wstb = 1'b0;
    bus.i_bus_r_wn = 1'b1;
    rst = 1'b1;
    m_reset();
    probe(16'hC000, 1'b0);
    chk("rst.fl_addr", 32'(bus.o_fl_addr), 32'h0003C000);
    check_outs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    m_cyc++;
    #1;
  endtask

  initial begin
    bus.i_bus_addr  = 16'h0000;
    bus.i_bus_wdata = 8'h00;
    bus.i_bus_r_wn  = 1'b1;
    bus.i_bus_wstb  = 1'b0;
    bus.i_ppu_a12   = 1'b0;
    bus.i_fl_rdata  = 8'h00;
    rst = 1'b1;

    // Reset state: top bank fixed at $C000, mirror 0, PRG-RAM enabled
    do_reset();
    probe(16'hC000, 1'b0);
    chk("t1.fl_addr", 32'(bus.o_fl_addr), 32'h0003C000);
    chk("t1.mirror", 32'(bus.o_mirror_mode), 32'd0);
    chk("t1.wram_en", 32'(bus.o_wram_en), 32'd1);
    chk("t1.sram_ext", 32'(bus.o_sram_addr_ext), 32'd0);
    chk("t1.rdata", 32'(bus.o_mmc_rdata), 32'h5A);
    probe(16'h1234, 1'b0);
    chk("t1.fl_low", 32'(bus.o_fl_addr), 32'd0);
    chk("t1.rdata_low", 32'(bus.o_mmc_rdata), 32'd0);

    // PRG register load
    load(16'hE000, 5'h0A);
    probe(16'h8000, 1'b0);
    chk("t2.fl_addr", 32'(bus.o_fl_addr), 32'h00028000);

    // Partial load aborted by a $80 write, then a full CHR0 load
    do_reset();
    ser(16'h8000, 1'b1);
    ser(16'h8000, 1'b1);
    ser(16'h8000, 1'b1);
    cyc(16'h8000, 8'h80, 1'b0, 1'b1, 1'b0, "abort");
    idle(16'h8000);
    idle(16'h8000);
    load(16'hA000, 5'h1F);
    probe(16'h0000, 1'b0);
    chk("t3.chr_a12_0", 32'(bus.o_sram_addr_ext), 32'h1E);
    probe(16'h0000, 1'b1);
    chk("t3.chr_a12_1", 32'(bus.o_sram_addr_ext), 32'h1F);
    probe(16'hC000, 1'b0);
    chk("t3.fl_mode3", 32'(bus.o_fl_addr), 32'h0003C000);
    chk("t3.mirror", 32'(bus.o_mirror_mode), 32'd0);
    chk("t3.wram_en", 32'(bus.o_wram_en), 32'd1);

    // 4 KB CHR mode with separate halves
    load(16'h8000, 5'h12);
    load(16'hC000, 5'h05);
    probe(16'hC000, 1'b1);
    chk("t4.chr1", 32'(bus.o_sram_addr_ext), 32'h05);
    chk("t4.mirror", 32'(bus.o_mirror_mode), 32'd1);
    chk("t4.fl_32k", 32'(bus.o_fl_addr), 32'h00004000);
    probe(16'hC000, 1'b0);
    chk("t4.chr0", 32'(bus.o_sram_addr_ext), 32'h1F);

    // Back-to-back strobes: the second one is filtered
    do_reset();
    cyc(16'hE000, 8'h01, 1'b0, 1'b1, 1'b0, "gap1");
    cyc(16'hE000, 8'h01, 1'b0, 1'b1, 1'b0, "gap2");
    idle(16'hE000);
    idle(16'hE000);
    for (int i = 0; i < 4; i++) ser(16'hE000, 1'b0);
    probe(16'h8000, 1'b0);
    chk("t5.fl_addr", 32'(bus.o_fl_addr), 32'h00004000);

    // Reset after the fourth serial write discards the partial value
    do_reset();
    for (int i = 0; i < 4; i++) ser(16'hE000, 1'b1);
    do_reset();
    probe(16'h8000, 1'b0);
    chk("t6.fl_rst", 32'(bus.o_fl_addr), 32'd0);
    load(16'hE000, 5'h05);
    probe(16'h8000, 1'b0);
    chk("t6.fl_addr", 32'(bus.o_fl_addr), 32'h00014000);
    chk("t6.wram_en", 32'(bus.o_wram_en), 32'd1);

    // Random traffic, including back-to-back strobes and occasional resets
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [15:0] a;
      logic [7:0]  wd;
      logic        rwn, stb;
      a   = 16'($urandom);
      if ($urandom_range(3) != 0) a[15] = 1'b1;
      wd  = 8'($urandom);
      wd[7] = ($urandom_range(15) == 0);
      stb = ($urandom_range(2) == 0);
      rwn = stb ? ($urandom_range(5) == 0) : 1'($urandom);
      cyc(a, wd, rwn, stb, 1'($urandom), "rnd");
      if ($urandom_range(599) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
